// File: rtl/conv_1d_stream_if.sv
// Stream bundle for the 1-D convolver: one valid/ready channel carrying raw
// samples in, one valid/ready channel carrying filtered samples out.
interface conv_1d_stream_if #(
    parameter int DATA_W = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_last;
    logic                     out_sat;

    // Producer of input samples and consumer of results
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sat
    );

    // The convolver itself
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sat
    );
endinterface

// File: rtl/conv_1d_stream.sv
// Streaming 1-D convolver. Takes one line of LINE_LEN signed samples and
// emits LINE_LEN filtered samples using mirror padding at both line ends,
// a double-buffered kernel, rounding right shift and signed saturation.
// Only the last K samples are kept: reflected taps always land inside that
// window, so no full-line buffer is needed.
module conv_1d_stream #(
    parameter int DATA_W   = 8,
    parameter int COEF_W   = 8,
    parameter int K        = 3,
    parameter int LINE_LEN = 640,
    parameter int SHIFT    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     coef_we,
    input  logic [$clog2(K)-1:0]     coef_idx,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     busy,
    conv_1d_stream_if.slave          s
);
    localparam int H     = K / 2;
    localparam int IDX_W = $clog2(K);
    localparam int ACC_W = DATA_W + COEF_W + $clog2(K);
    localparam int CNT_W = $clog2(LINE_LEN + K);

    // Rounding bias and clamp limits, one bit wider than the accumulator so
    // that adding the bias can never wrap.
    localparam logic signed [ACC_W:0] RND_BIAS =
        (SHIFT > 0) ? ((ACC_W+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'(2**(DATA_W-1) - 1);
    localparam logic signed [ACC_W:0] MIN_V = -(ACC_W+1)'(2**(DATA_W-1));

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t                   state, state_next;
    // cnt is the index of the next sample to accept; during FLUSH it keeps
    // counting as a virtual index so that out index = cnt - H throughout.
    logic [CNT_W-1:0]         cnt;
    logic signed [DATA_W-1:0] hist   [K];
    logic signed [COEF_W-1:0] shadow [K];
    logic signed [COEF_W-1:0] active [K];

    logic                     in_ready_c, in_fire, out_fire, flush_load, load;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W:0]    rnd, shifted;
    logic signed [DATA_W-1:0] res;
    logic                     res_sat;

    logic                     out_valid_r, out_last_r, out_sat_r;
    logic signed [DATA_W-1:0] out_data_r;

    assign s.in_ready  = in_ready_c;
    assign s.out_valid = out_valid_r;
    assign s.out_data  = out_data_r;
    assign s.out_last  = out_last_r;
    assign s.out_sat   = out_sat_r;

    // Handshake qualification and next-state selection
    always_comb begin
        state_next = state;
        in_ready_c = (state == FILL) ||
                     (((state == IDLE) || (state == RUN)) && (!out_valid_r || s.out_ready));
        in_fire    = s.in_valid && in_ready_c;
        out_fire   = out_valid_r && s.out_ready;
        flush_load = (state == FLUSH) && (cnt < CNT_W'(LINE_LEN + H)) &&
                     (!out_valid_r || s.out_ready);
        load       = (in_fire && (cnt >= CNT_W'(H))) || flush_load;
        case (state)
            IDLE:    if (in_fire) state_next = FILL;
            FILL:    if (in_fire && (cnt == CNT_W'(H))) state_next = RUN;
            RUN:     if (in_fire && (cnt == CNT_W'(LINE_LEN - 1))) state_next = FLUSH;
            FLUSH:   if (out_fire && out_last_r) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Gather the mirrored window around out index cnt-H and accumulate taps
    always_comb begin : window_mac
        int newest, m, r, off;
        logic signed [DATA_W-1:0] samp;
        acc    = '0;
        newest = (state == FLUSH) ? LINE_LEN - 1 : int'(cnt);
        for (int j = 0; j < K; j++) begin
            m = int'(cnt) - 2*H + j;
            if (m < 0)                 r = -m;
            else if (m > LINE_LEN - 1) r = 2*(LINE_LEN - 1) - m;
            else                       r = m;
            off = newest - r;
            if (off < 0)     off = 0;
            if (off > K - 1) off = K - 1;
            if (state == FLUSH) samp = hist[IDX_W'(off)];
            else if (off == 0)  samp = s.in_data;
            else                samp = hist[IDX_W'(off - 1)];
            acc = acc + ACC_W'(samp) * ACC_W'(active[IDX_W'(j)]);
        end
    end

    // Round half up, arithmetic shift, then clamp into the sample range
    always_comb begin
        rnd     = {acc[ACC_W-1], acc} + RND_BIAS;
        shifted = rnd >>> SHIFT;
        res_sat = 1'b0;
        if (shifted > MAX_V) begin
            res     = MAX_V[DATA_W-1:0];
            res_sat = 1'b1;
        end else if (shifted < MIN_V) begin
            res     = MIN_V[DATA_W-1:0];
            res_sat = 1'b1;
        end else begin
            res     = shifted[DATA_W-1:0];
        end
    end

    // State register, sample counter and line-busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == FLUSH) && out_fire && out_last_r) begin
                cnt  <= '0;
                busy <= 1'b0;
            end else if (in_fire || flush_load) begin
                cnt <= cnt + 1'b1;
            end
            if ((state == IDLE) && in_fire) busy <= 1'b1;
        end
    end

    // Sample history, newest sample at index 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < K; d++) hist[d] <= '0;
        end else if (in_fire) begin
            hist[0] <= s.in_data;
            for (int d = 1; d < K; d++) hist[d] <= hist[d-1];
        end
    end

    // Shadow bank takes writes any time; active bank is latched at line start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < K; d++) begin
                shadow[d] <= (d == H) ? COEF_W'(1) : '0;
                active[d] <= (d == H) ? COEF_W'(1) : '0;
            end
        end else begin
            if ((state == IDLE) && in_fire) begin
                for (int d = 0; d < K; d++) active[d] <= shadow[d];
            end
            if (coef_we && (32'(coef_idx) < K)) shadow[coef_idx] <= coef_data;
        end
    end

    // Output register: load a new result or drain; hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            out_sat_r   <= 1'b0;
        end else if (load) begin
            out_valid_r <= 1'b1;
            out_data_r  <= res;
            out_sat_r   <= res_sat;
            out_last_r  <= (cnt == CNT_W'(LINE_LEN - 1 + H));
        end else if (out_fire) begin
            out_valid_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_conv_1d_stream.sv
// Self-checking bench for conv_1d_stream. Two instances share all inputs:
// one with SHIFT=0 and one with SHIFT=2, so every line exercises both the
// plain and the rounding/shift paths. Expected values come from a direct
// arithmetic model of the filter equation.
module tb_conv_1d_stream;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int K  = 3;
    localparam int L  = 8;

    typedef int line_t [L];
    typedef int kern_t [K];

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 coef_we;
    logic [1:0]           coef_idx;
    logic signed [CW-1:0] coef_data;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 out_ready;
    logic                 busy0, busy2;

    int checks   = 0;
    int failures = 0;

    // Observations collected by drive_line
    int obs_d0 [L];
    int obs_d2 [L];
    bit obs_s0 [L];
    bit obs_s2 [L];
    bit obs_l0 [L];
    bit obs_l2 [L];
    int n_out, cycles, stall_err, flush_err, busy_err;

    conv_1d_stream_if #(.DATA_W(DW)) if0 ();
    conv_1d_stream_if #(.DATA_W(DW)) if2 ();

    assign if0.in_valid  = in_valid;
    assign if0.in_data   = in_data;
    assign if0.out_ready = out_ready;
    assign if2.in_valid  = in_valid;
    assign if2.in_data   = in_data;
    assign if2.out_ready = out_ready;

    conv_1d_stream #(.DATA_W(DW), .COEF_W(CW), .K(K), .LINE_LEN(L), .SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_idx(coef_idx),
        .coef_data(coef_data), .busy(busy0), .s(if0)
    );

    conv_1d_stream #(.DATA_W(DW), .COEF_W(CW), .K(K), .LINE_LEN(L), .SHIFT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_idx(coef_idx),
        .coef_data(coef_data), .busy(busy2), .s(if2)
    );

    always #5 clk = ~clk;

    // Mirror index without repeating the edge sample
    function automatic int refl(input int n);
        if (n < 0) return -n;
        if (n > L - 1) return 2*(L - 1) - n;
        return n;
    endfunction

    // out[i] straight from the filter equation
    function automatic void model(input line_t x, input kern_t k, input int shift,
                                  input int i, output int val, output bit sat);
        int acc;
        acc = 0;
        for (int j = 0; j < K; j++) acc += k[j] * x[refl(i - K/2 + j)];
        if (shift > 0) acc = (acc + (1 << (shift - 1))) >>> shift;
        sat = 1'b1;
        if (acc > 127)       val = 127;
        else if (acc < -128) val = -128;
        else begin val = acc; sat = 1'b0; end
    endfunction

    task automatic set_kernel(input kern_t k);
        for (int j = 0; j < K; j++) begin
            coef_we = 1'b1; coef_idx = 2'(j); coef_data = 8'(k[j]);
            @(posedge clk); #1;
        end
        coef_we = 1'b0;
    endtask

    function automatic line_t rand_line(input int lo, input int span);
        line_t x;
        for (int i = 0; i < L; i++) x[i] = int'($urandom_range(span)) + lo;
        return x;
    endfunction

    // Feed one line with random gaps/backpressure and record what comes out
    task automatic drive_line(input line_t x, input int pin, input int pout,
                              input bit mid_write, input kern_t wk);
        int acc_cnt, wr_step;
        bit fire, stall;
        logic [9:0] h0, h2;
        acc_cnt = 0; wr_step = 0; stall = 1'b0; h0 = '0; h2 = '0;
        n_out = 0; cycles = 0; stall_err = 0; flush_err = 0; busy_err = 0;
        coef_we   = 1'b0;
        in_valid  = ($urandom_range(99) < pin);
        in_data   = 8'(x[0]);
        out_ready = ($urandom_range(99) < pout);
        while (n_out < L && cycles < 400) begin
            @(negedge clk);
            if (stall && (!if0.out_valid || {if0.out_data, if0.out_sat, if0.out_last} !== h0 ||
                          !if2.out_valid || {if2.out_data, if2.out_sat, if2.out_last} !== h2))
                stall_err++;
            if (acc_cnt == L && (if0.in_ready || if2.in_ready)) flush_err++;
            if (acc_cnt >= 1 && !(busy0 && busy2)) busy_err++;
            fire = in_valid && if0.in_ready;
            if (if0.out_valid && out_ready) begin
                obs_d0[n_out] = if0.out_data; obs_s0[n_out] = if0.out_sat; obs_l0[n_out] = if0.out_last;
                obs_d2[n_out] = if2.out_data; obs_s2[n_out] = if2.out_sat; obs_l2[n_out] = if2.out_last;
                n_out++;
            end
            stall = if0.out_valid && !out_ready;
            h0 = {if0.out_data, if0.out_sat, if0.out_last};
            h2 = {if2.out_data, if2.out_sat, if2.out_last};
            if (fire) acc_cnt++;
            @(posedge clk); #1;
            cycles++;
            coef_we = 1'b0;
            if (mid_write && acc_cnt >= 2 && wr_step < K) begin
                coef_we = 1'b1; coef_idx = 2'(wr_step); coef_data = 8'(wk[wr_step]);
                wr_step++;
            end
            if (fire || !in_valid) begin
                if (acc_cnt < L) begin
                    in_valid = ($urandom_range(99) < pin);
                    in_data  = 8'(x[acc_cnt]);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(99) < pout);
        end
        in_valid = 1'b0; out_ready = 1'b0; coef_we = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({if0.out_valid, if0.out_data, if0.out_last, if0.out_sat, busy0, if0.in_ready} !== 13'b0_00000000_0001) begin
            failures++;
            $display("FAIL reset_s0: got v=%0b d=%0d l=%0b s=%0b busy=%0b rdy=%0b, want 0 0 0 0 0 1",
                     if0.out_valid, if0.out_data, if0.out_last, if0.out_sat, busy0, if0.in_ready);
        end
        checks++;
        if ({if2.out_valid, if2.out_data, if2.out_last, if2.out_sat, busy2, if2.in_ready} !== 13'b0_00000000_0001) begin
            failures++;
            $display("FAIL reset_s2: got v=%0b d=%0d l=%0b s=%0b busy=%0b rdy=%0b, want 0 0 0 0 0 1",
                     if2.out_valid, if2.out_data, if2.out_last, if2.out_sat, busy2, if2.in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_passthrough();
        line_t x = '{5, -3, 7, 0, 1, 2, -128, 127};
        kern_t k = '{0, 1, 0};
        int e; bit sx;
        // tap index 3 is out of range and must be ignored
        coef_we = 1'b1; coef_idx = 2'd3; coef_data = 8'sd9;
        @(posedge clk); #1;
        coef_we = 1'b0;
        drive_line(x, 100, 100, 1'b0, k);
        checks++;
        if (n_out != L) begin failures++; $display("FAIL passthrough_timeout: got %0d outputs, want %0d", n_out, L); end
        checks++;
        if (cycles > L + 2) begin failures++; $display("FAIL passthrough_throughput: got %0d cycles, want <= %0d", cycles, L + 2); end
        for (int i = 0; i < L; i++) begin
            checks++;
            if (obs_d0[i] !== x[i] || obs_s0[i] !== 1'b0 || obs_l0[i] !== (i == L - 1)) begin
                failures++;
                $display("FAIL passthrough_s0 out[%0d]: got %0d sat=%0b last=%0b, want %0d sat=0 last=%0b",
                         i, obs_d0[i], obs_s0[i], obs_l0[i], x[i], i == L - 1);
            end
            model(x, k, 2, i, e, sx);
            checks++;
            if (obs_d2[i] !== e || obs_s2[i] !== sx || obs_l2[i] !== (i == L - 1)) begin
                failures++;
                $display("FAIL passthrough_s2 out[%0d]: got %0d sat=%0b, want %0d sat=%0b", i, obs_d2[i], obs_s2[i], e, sx);
            end
        end
        checks++;
        if (busy0 || busy2 || busy_err != 0) begin
            failures++;
            $display("FAIL passthrough_busy: got end=%0b%0b midline_low=%0d, want end=00 midline_low=0", busy0, busy2, busy_err);
        end
    endtask

    task automatic test_smoothing();
        line_t x    = '{0, 1, 2, 3, 4, 5, 6, 7};
        line_t want = '{1, 1, 2, 3, 4, 5, 6, 7};
        kern_t k    = '{1, 2, 1};
        int e; bit sx;
        set_kernel(k);
        drive_line(x, 100, 100, 1'b0, k);
        checks++;
        if (n_out != L || flush_err != 0) begin
            failures++;
            $display("FAIL smoothing_flow: got outputs=%0d flush_ready=%0d, want %0d and 0", n_out, flush_err, L);
        end
        for (int i = 0; i < L; i++) begin
            checks++;
            if (obs_d2[i] !== want[i] || obs_s2[i] !== 1'b0 || obs_l2[i] !== (i == L - 1)) begin
                failures++;
                $display("FAIL smoothing_s2 out[%0d]: got %0d sat=%0b last=%0b, want %0d sat=0 last=%0b",
                         i, obs_d2[i], obs_s2[i], obs_l2[i], want[i], i == L - 1);
            end
            model(x, k, 0, i, e, sx);
            checks++;
            if (obs_d0[i] !== e || obs_s0[i] !== sx) begin
                failures++;
                $display("FAIL smoothing_s0 out[%0d]: got %0d sat=%0b, want %0d sat=%0b", i, obs_d0[i], obs_s0[i], e, sx);
            end
        end
    endtask

    task automatic test_saturation();
        kern_t k = '{1, 2, 1};
        line_t x;
        int e; bit sx;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < L; i++) x[i] = (pass == 0) ? 127 : -128;
            drive_line(x, 100, 100, 1'b0, k);
            for (int i = 0; i < L; i++) begin
                checks++;
                if (i >= n_out || obs_d0[i] !== x[i] || obs_s0[i] !== 1'b1) begin
                    failures++;
                    $display("FAIL saturation_s0 out[%0d]: got %0d sat=%0b, want %0d sat=1", i, obs_d0[i], obs_s0[i], x[i]);
                end
                model(x, k, 2, i, e, sx);
                checks++;
                if (obs_d2[i] !== e || obs_s2[i] !== sx) begin
                    failures++;
                    $display("FAIL saturation_s2 out[%0d]: got %0d sat=%0b, want %0d sat=%0b", i, obs_d2[i], obs_s2[i], e, sx);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        line_t x = '{0, 1, 2, 3, 4, 5, 6, 7};
        kern_t k = '{1, 2, 1};
        int e; bit sx;
        for (int rep = 0; rep < 3; rep++) begin
            drive_line(x, 70, 50, 1'b0, k);
            checks++;
            if (n_out != L || stall_err != 0 || flush_err != 0 || busy_err != 0) begin
                failures++;
                $display("FAIL backpressure_flow: got outputs=%0d unstable=%0d flush_ready=%0d busy_low=%0d, want %0d 0 0 0",
                         n_out, stall_err, flush_err, busy_err, L);
            end
            for (int i = 0; i < L; i++) begin
                for (int sh = 0; sh <= 2; sh += 2) begin
                    model(x, k, sh, i, e, sx);
                    checks++;
                    if ((sh == 0 ? obs_d0[i] : obs_d2[i]) !== e || (sh == 0 ? obs_s0[i] : obs_s2[i]) !== sx ||
                        (sh == 0 ? obs_l0[i] : obs_l2[i]) !== (i == L - 1)) begin
                        failures++;
                        $display("FAIL backpressure_shift%0d out[%0d]: got %0d, want %0d sat=%0b", sh, i,
                                 sh == 0 ? obs_d0[i] : obs_d2[i], e, sx);
                    end
                end
            end
        end
    endtask

    task automatic test_kernel_double_buffer();
        kern_t k_old = '{1, 2, 1};
        kern_t k_new = '{0, 0, 2};
        line_t x;
        int e; bit sx;
        for (int ln = 0; ln < 2; ln++) begin
            x = rand_line(-60, 120);
            drive_line(x, 80, 70, ln == 0, k_new);
            for (int i = 0; i < L; i++) begin
                for (int sh = 0; sh <= 2; sh += 2) begin
                    model(x, ln == 0 ? k_old : k_new, sh, i, e, sx);
                    checks++;
                    if (i >= n_out || (sh == 0 ? obs_d0[i] : obs_d2[i]) !== e || (sh == 0 ? obs_s0[i] : obs_s2[i]) !== sx) begin
                        failures++;
                        $display("FAIL kernel_line%0d_shift%0d out[%0d]: got %0d, want %0d", ln + 1, sh, i,
                                 sh == 0 ? obs_d0[i] : obs_d2[i], e);
                    end
                end
            end
        end
        checks++;
        if (obs_d0[L-1] !== 2 * x[L-2]) begin
            failures++;
            $display("FAIL kernel_right_mirror: got %0d, want %0d", obs_d0[L-1], 2 * x[L-2]);
        end
    endtask

    task automatic test_random();
        kern_t k;
        line_t x;
        int e; bit sx;
        for (int ln = 0; ln < 4; ln++) begin
            for (int j = 0; j < K; j++) k[j] = int'($urandom_range(8)) - 4;
            set_kernel(k);
            x = rand_line(-128, 255);
            drive_line(x, 75, 60, 1'b0, k);
            checks++;
            if (n_out != L || stall_err != 0 || flush_err != 0) begin
                failures++;
                $display("FAIL random_flow line%0d: got outputs=%0d unstable=%0d flush_ready=%0d", ln, n_out, stall_err, flush_err);
            end
            for (int i = 0; i < L; i++) begin
                for (int sh = 0; sh <= 2; sh += 2) begin
                    model(x, k, sh, i, e, sx);
                    checks++;
                    if ((sh == 0 ? obs_d0[i] : obs_d2[i]) !== e || (sh == 0 ? obs_s0[i] : obs_s2[i]) !== sx) begin
                        failures++;
                        $display("FAIL random_line%0d_shift%0d out[%0d]: got %0d sat=%0b, want %0d sat=%0b", ln, sh, i,
                                 sh == 0 ? obs_d0[i] : obs_d2[i], sh == 0 ? obs_s0[i] : obs_s2[i], e, sx);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midline();
        line_t xa = rand_line(-128, 255);
        line_t x  = rand_line(-128, 255);
        kern_t k  = '{0, 1, 0};
        int e; bit sx;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(xa[i]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        checks++;
        if (!(if0.out_valid && busy0)) begin
            failures++;
            $display("FAIL midline_precondition: got out_valid=%0b busy=%0b, want 1 1", if0.out_valid, busy0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({if0.out_valid, if0.out_data, if0.out_last, if0.out_sat, busy0,
             if2.out_valid, if2.out_data, if2.out_last, if2.out_sat, busy2} !== 24'd0) begin
            failures++;
            $display("FAIL midline_async_clear: got v=%0b d=%0d busy=%0b / v=%0b d=%0d busy=%0b, want all 0",
                     if0.out_valid, if0.out_data, busy0, if2.out_valid, if2.out_data, busy2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (!(if0.in_ready && if2.in_ready)) begin
            failures++;
            $display("FAIL midline_ready_after_reset: got %0b%0b, want 11", if0.in_ready, if2.in_ready);
        end
        drive_line(x, 80, 70, 1'b0, k);
        for (int i = 0; i < L; i++) begin
            for (int sh = 0; sh <= 2; sh += 2) begin
                model(x, k, sh, i, e, sx);
                checks++;
                if (i >= n_out || (sh == 0 ? obs_d0[i] : obs_d2[i]) !== e || (sh == 0 ? obs_l0[i] : obs_l2[i]) !== (i == L - 1)) begin
                    failures++;
                    $display("FAIL midline_fresh_shift%0d out[%0d]: got %0d, want %0d", sh, i,
                             sh == 0 ? obs_d0[i] : obs_d2[i], e);
                end
            end
        end
    endtask

    // Scenario sequence
    initial begin
        rst_n = 1'b0; coef_we = 1'b0; coef_idx = '0; coef_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_passthrough();
        test_smoothing();
        test_saturation();
        test_backpressure();
        test_kernel_double_buffer();
        test_random();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000, want completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/conv_1d_stream.md
Name: conv_1d_stream

Overview:
- Streaming, parametrised successor to the combinational 1-D convolver.
- Accepts one line of LINE_LEN signed samples over a valid/ready stream and emits LINE_LEN filtered samples over a second valid/ready stream.
- Uses symmetric mirror padding at both line ends, a double-buffered runtime-loadable kernel, rounding right-shift and signed saturation.
- Sits between the pixel source and the 2-D convolution / line-buffer stages.

Parameters:
- DATA_W, 8, signed sample width (in and out).
- COEF_W, 8, signed coefficient width.
- K, 3, kernel taps; must be odd, 3..15; H = K/2.
- LINE_LEN, 640, samples per line; must be >= K.
- SHIFT, 0, arithmetic right shift applied to the accumulator, 0..ACC_W-1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- coef_we  in  1  write strobe, shadow kernel bank.
- coef_idx  in  $clog2(K)  tap index; writes with idx >= K are ignored.
- coef_data  in  COEF_W  signed coefficient.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  signed input sample.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  signed filtered sample.
- out_last  out  1  marks output index LINE_LEN-1.
- out_sat  out  1  out_data was clamped.
- busy  out  1  high from the first accepted sample of a line until the last output is taken.

Behaviour:
- Function: out[i] = sat(rnd(sum_j kernel[j]*x[r(i-H+j)]) >>> SHIFT), j = 0..K-1.
  - r(n) = -n for n<0; 2*(LINE_LEN-1)-n for n>LINE_LEN-1; else n. Edge sample is not repeated.
- Arithmetic:
  - Products are full precision; accumulator ACC_W = DATA_W+COEF_W+$clog2(K), signed.
  - If SHIFT>0, add 2**(SHIFT-1) before the arithmetic shift (round half up).
  - Clamp to [-2**(DATA_W-1), 2**(DATA_W-1)-1]; out_sat=1 when clamped. No wrap.
- Storage: history of the last K accepted samples plus a sample counter. Reflected indices always fall inside this history, so no full-line buffer is needed.
- FSM:
  - IDLE: in_ready=1. The first handshake stores x[0], copies shadow->active kernel, sets busy, and moves to FILL.
  - FILL: accept samples until x[H] is held, then move to RUN.
    - The cycle x[H] is accepted, out[0] is computed.
  - RUN: each accepted x[i+H] produces out[i], registered into the output register on the next edge (latency 1 clk from the handshake).
    - After x[LINE_LEN-1] is accepted, move to FLUSH.
  - FLUSH: in_ready=0; emits out[LINE_LEN-H..LINE_LEN-1], one per cycle whenever the output register is free or being drained.
    - When out_last is handshaked, return to IDLE with busy=0.
- Flow control:
  - in_ready = (state in IDLE/FILL/RUN) and (FILL or !out_valid or out_ready).
  - FILL never blocks on the output.
  - The output register holds data and flags stable while out_valid && !out_ready.
  - Zero-bubble throughput: 1 sample/clk when out_ready is held high.
- out_last = 1 only with out[LINE_LEN-1]. A new line's first sample is accepted in IDLE, i.e. the cycle after the out_last handshake.
- Kernel:
  - coef_we writes the shadow bank at any time.
  - The active bank is loaded only at a line start. A write in the same cycle as the line-start copy does not reach the active bank this line; it takes effect on the next line.
  - Mid-line writes never alter the current line.
- Reset (async, any state, including mid-line):
  - State=IDLE, counter=0, history=0; out_valid=0, out_data=0, out_last=0, out_sat=0, busy=0, in_ready=1 after deassertion.
  - Both kernel banks = 0 except tap H = 1.
  - Any partial line is discarded.

Test Plan:
- Reset passthrough: SHIFT=0, reset kernel, LINE_LEN=8, in 5,-3,7,0,1,2,-128,127 -> identical out, out_last on 8th output, out_sat=0 throughout.
- Smoothing and mirror: LINE_LEN=8, K=3, SHIFT=2, kernel [1,2,1], ramp 0..7 -> out 1,1,2,3,4,5,6,7. Checks both reflections and rounding.
- Saturation: SHIFT=0, kernel [1,2,1], line of all 127 -> all out 127 with out_sat=1. Line of all -128 -> all -128 with out_sat=1.
- Backpressure: ramp test with random out_ready (~50%) and random in_valid gaps -> same values as the smoothing test, no loss or duplication, out_data stable while stalled, in_ready=0 during FLUSH.
- Kernel double-buffer: write kernel [0,0,2] during line 1 -> line 1 is unchanged; line 2 out[i] = 2*x[r(i+1)], with out[7] = 2*x[6].
- Reset mid-line: assert rst_n=0 after 4 of 8 samples, with out_valid high -> all outputs clear asynchronously. A fresh full line then produces a correct complete output with no residue from the aborted line.
